// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system ID and timestamp words from the
// sysid slave, compares them to build-time values and posts a sticky verdict.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1683891951,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  error_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, REQ, LAT, CHECK, DONE} state_e;

  localparam logic [1:0]  LAT_N  = 2'(READ_LATENCY);
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic        idx_q, idx_d;
  logic [15:0] wait_q, wait_d;
  logic [1:0]  lat_q, lat_d;
  logic        boot_q;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        capture;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    lat_d   = lat_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    id_d    = id_q;
    ts_d    = ts_q;
    capture = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // boot_q is only high in the first cycle out of reset, which provides the auto-start
        if (start || (AUTO_START && boot_q)) begin
          state_d = REQ;
          idx_d   = 1'b0;
          wait_d  = '0;
          lat_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = 2'd0;
        end
      end
      REQ: begin
        if (avm_waitrequest) begin
          if (wait_q + 16'd1 == TO_LIM) begin
            state_d = DONE;
            wait_d  = '0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            err_d   = 2'd3;
          end else begin
            wait_d = wait_q + 16'd1;
          end
        end else begin
          wait_d = '0;
          if (LAT_N == 2'd0) begin
            capture = 1'b1;
          end else begin
            state_d = LAT;
            lat_d   = 2'd1;
          end
        end
      end
      LAT: begin
        if (lat_q == LAT_N) begin
          capture = 1'b1;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      CHECK: begin
        state_d = DONE;
        done_d  = 1'b1;
        if (id_q != EXPECTED_ID) begin
          err_d  = 2'd1;
          pass_d = 1'b0;
        end else if (ts_q != EXPECTED_TS) begin
          err_d  = 2'd2;
          pass_d = 1'b0;
        end else begin
          err_d  = 2'd0;
          pass_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared by the zero-latency accept and the end of the LAT wait
    if (capture) begin
      lat_d = '0;
      if (!idx_q) begin
        id_d    = avm_readdata;
        idx_d   = 1'b1;
        state_d = REQ;
      end else begin
        ts_d    = avm_readdata;
        state_d = CHECK;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 1'b0;
      wait_q  <= '0;
      lat_q   <= '0;
      boot_q  <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 2'd0;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      lat_q   <= lat_d;
      boot_q  <= 1'b0;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  assign avm_read    = (state_q == REQ);
  assign avm_address = avm_read & idx_q;
  assign busy        = (state_q == REQ) || (state_q == LAT) || (state_q == CHECK);
  assign done        = done_q;
  assign pass        = pass_q;
  assign error_code  = err_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench: instance A is a zero-wait, zero-latency sysid slave with auto-start;
// instance B adds waitrequest stalls, 2-cycle read latency and a short timeout.
module tb_sysid_checker;

  localparam logic [31:0] TS_OK = 32'd1683891951;
  localparam logic [31:0] ID_B  = 32'hC0FFEE01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A signals
  logic        reset_a, start_a;
  logic        wr_a = 1'b0;
  logic [31:0] id_a, ts_a;
  logic        addr_a, read_a, busy_a, done_a, pass_a;
  logic [1:0]  err_a;
  logic [31:0] idv_a, tsv_a, rdata_a;
  int          acc_a = 0;

  assign rdata_a = addr_a ? ts_a : id_a;

  always @(posedge clk)
    if (read_a === 1'b1 && wr_a === 1'b0) acc_a <= acc_a + 1;

  sysid_checker dut_a (
    .clock(clk), .reset(reset_a), .start(start_a),
    .avm_address(addr_a), .avm_read(read_a),
    .avm_waitrequest(wr_a), .avm_readdata(rdata_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .error_code(err_a),
    .id_value(idv_a), .ts_value(tsv_a)
  );

  // Instance B signals
  logic        reset_b, start_b, stuck_b;
  logic [31:0] id_b, ts_b;
  logic        addr_b, read_b, busy_b, done_b, pass_b, wr_b;
  logic [1:0]  err_b;
  logic [31:0] idv_b, tsv_b, rdata_b;
  logic [3:0]  scnt_b = '0;
  logic        p1 = 1'b0, p2 = 1'b0, a1 = 1'b0, a2 = 1'b0;

  // Slave stalls 3 cycles per read (or forever when stuck) and returns data
  // exactly 2 cycles after the accept; other cycles carry junk.
  assign wr_b    = read_b & (stuck_b | (scnt_b < 4'd3));
  assign rdata_b = p2 ? (a2 ? ts_b : id_b) : 32'hDEADBEEF;

  always @(posedge clk) begin
    scnt_b <= (read_b === 1'b1 && wr_b === 1'b1) ? scnt_b + 4'd1 : 4'd0;
    p1 <= (read_b === 1'b1 && wr_b === 1'b0);
    a1 <= addr_b;
    p2 <= p1;
    a2 <= a1;
  end

  sysid_checker #(
    .EXPECTED_ID(ID_B),
    .EXPECTED_TS(TS_OK),
    .READ_LATENCY(2),
    .TIMEOUT(10),
    .AUTO_START(1'b0)
  ) dut_b (
    .clock(clk), .reset(reset_b), .start(start_b),
    .avm_address(addr_b), .avm_read(read_b),
    .avm_waitrequest(wr_b), .avm_readdata(rdata_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .error_code(err_b),
    .id_value(idv_b), .ts_value(tsv_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] rdv, adv;
  int          bc;
  int          a0;

  initial begin
    reset_a = 1'b1; start_a = 1'b0; id_a = 32'd0; ts_a = TS_OK;
    reset_b = 1'b1; start_b = 1'b0; stuck_b = 1'b0; id_b = ID_B; ts_b = TS_OK;
    tick();
    tick();

    // Reset state
    chk("rst_read_a",  {31'd0, read_a}, 32'd0);
    chk("rst_addr_a",  {31'd0, addr_a}, 32'd0);
    chk("rst_busy_a",  {31'd0, busy_a}, 32'd0);
    chk("rst_done_a",  {31'd0, done_a}, 32'd0);
    chk("rst_pass_a",  {31'd0, pass_a}, 32'd0);
    chk("rst_err_a",   {30'd0, err_a},  32'd0);
    chk("rst_id_a",    idv_a, 32'd0);
    chk("rst_ts_a",    tsv_a, 32'd0);
    chk("rst_read_b",  {31'd0, read_b}, 32'd0);

    // Test 1: auto-start, zero-wait slave
    reset_a = 1'b0; reset_b = 1'b0;
    tick();
    chk("t1_read0",  {31'd0, read_a}, 32'd1);
    chk("t1_addr0",  {31'd0, addr_a}, 32'd0);
    chk("t1_busy",   {31'd0, busy_a}, 32'd1);
    chk("t1_noauto_b", {31'd0, read_b}, 32'd0);
    tick();
    chk("t1_read1",  {31'd0, read_a}, 32'd1);
    chk("t1_addr1",  {31'd0, addr_a}, 32'd1);
    tick();
    chk("t1_check_read", {31'd0, read_a}, 32'd0);
    chk("t1_check_busy", {31'd0, busy_a}, 32'd1);
    chk("t1_check_done", {31'd0, done_a}, 32'd0);
    tick();
    chk("t1_done",  {31'd0, done_a}, 32'd1);
    chk("t1_pass",  {31'd0, pass_a}, 32'd1);
    chk("t1_err",   {30'd0, err_a},  32'd0);
    chk("t1_busy0", {31'd0, busy_a}, 32'd0);
    chk("t1_id",    idv_a, 32'd0);
    chk("t1_ts",    tsv_a, TS_OK);
    chk("t1_reads", 32'(acc_a), 32'd2);
    chk("t1_idle_b", {31'd0, done_b}, 32'd0);

    // Test 2: ID mismatch
    id_a = 32'h12345678;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("t2_done_clr", {31'd0, done_a}, 32'd0);
    chk("t2_read",     {31'd0, read_a}, 32'd1);
    tick(); tick(); tick();
    chk("t2_done", {31'd0, done_a}, 32'd1);
    chk("t2_pass", {31'd0, pass_a}, 32'd0);
    chk("t2_err",  {30'd0, err_a},  32'd1);
    chk("t2_id",   idv_a, 32'h12345678);
    chk("t2_ts",   tsv_a, TS_OK);

    // Test 5: restart from DONE, timestamp mismatch, start held while busy
    id_a = 32'd0;
    ts_a = TS_OK - 32'd1;
    a0 = acc_a;
    start_a = 1'b1;
    tick();
    chk("t5_done_clr", {31'd0, done_a}, 32'd0);
    chk("t5_addr0",    {31'd0, addr_a}, 32'd0);
    tick();
    chk("t5_read1", {31'd0, read_a}, 32'd1);
    chk("t5_addr1", {31'd0, addr_a}, 32'd1);
    tick();
    chk("t5_check_read", {31'd0, read_a}, 32'd0);
    chk("t5_check_busy", {31'd0, busy_a}, 32'd1);
    tick();
    start_a = 1'b0;
    chk("t5_done",  {31'd0, done_a}, 32'd1);
    chk("t5_pass",  {31'd0, pass_a}, 32'd0);
    chk("t5_err",   {30'd0, err_a},  32'd2);
    chk("t5_ts",    tsv_a, TS_OK - 32'd1);
    chk("t5_reads", 32'(acc_a - a0), 32'd2);
    tick();
    chk("t5_hold_done", {31'd0, done_a}, 32'd1);
    chk("t5_hold_read", {31'd0, read_a}, 32'd0);

    // Test 6: reset during the second read, then fresh auto-start sequence
    ts_a = TS_OK;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    chk("t6_read1", {31'd0, read_a}, 32'd1);
    chk("t6_addr1", {31'd0, addr_a}, 32'd1);
    reset_a = 1'b1;
    tick();
    chk("t6_rst_read", {31'd0, read_a}, 32'd0);
    chk("t6_rst_addr", {31'd0, addr_a}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("t6_rst_done", {31'd0, done_a}, 32'd0);
    chk("t6_rst_pass", {31'd0, pass_a}, 32'd0);
    chk("t6_rst_err",  {30'd0, err_a},  32'd0);
    chk("t6_rst_id",   idv_a, 32'd0);
    chk("t6_rst_ts",   tsv_a, 32'd0);
    reset_a = 1'b0;
    tick();
    chk("t6_auto_read", {31'd0, read_a}, 32'd1);
    chk("t6_auto_addr", {31'd0, addr_a}, 32'd0);
    tick(); tick(); tick();
    chk("t6_done", {31'd0, done_a}, 32'd1);
    chk("t6_pass", {31'd0, pass_a}, 32'd1);
    chk("t6_err",  {30'd0, err_a},  32'd0);
    chk("t6_ts",   tsv_a, TS_OK);

    // Test 3: 3 stall cycles per read, 2-cycle read latency
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    rdv = '0; adv = '0; bc = 0;
    for (int k = 0; k < 16; k++) begin
      rdv[k] = read_b;
      adv[k] = read_b & addr_b;
      if (busy_b) bc++;
      tick();
    end
    chk("t3_read_pattern", {16'd0, rdv}, 32'h03CF);
    chk("t3_addr_pattern", {16'd0, adv}, 32'h03C0);
    chk("t3_busy_cycles",  32'(bc), 32'd13);
    chk("t3_done", {31'd0, done_b}, 32'd1);
    chk("t3_pass", {31'd0, pass_b}, 32'd1);
    chk("t3_err",  {30'd0, err_b},  32'd0);
    chk("t3_id",   idv_b, ID_B);
    chk("t3_ts",   tsv_b, TS_OK);

    // Test 4: waitrequest stuck high, TIMEOUT=10
    stuck_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    rdv = '0;
    for (int k = 0; k < 16; k++) begin
      rdv[k] = read_b;
      tick();
    end
    chk("t4_read_pattern", {16'd0, rdv}, 32'h03FF);
    chk("t4_done", {31'd0, done_b}, 32'd1);
    chk("t4_pass", {31'd0, pass_b}, 32'd0);
    chk("t4_err",  {30'd0, err_b},  32'd3);
    chk("t4_busy", {31'd0, busy_b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM read master that sits directly downstream of the system-ID slave and consumes its 32-bit readdata.
- At boot, or on request, it reads word 0 (system ID) and word 1 (timestamp), then compares both against build-time expected values.
- Publishes a sticky done/pass verdict and the captured words to CPU-side status logic and the board LEDs.
- Prevents software running on a mismatched hardware image.

Parameters:
- EXPECTED_ID, 32'd0: required value at address 0.
- EXPECTED_TS, 32'd1683891951: required value at address 1.
- READ_LATENCY, 0: cycles from accepted read to valid readdata. Range 0..3. 0 = data valid in the accept cycle.
- TIMEOUT, 255: maximum consecutive waitrequest cycles per read before abort. Range 1..65535.
- AUTO_START, 1: 1 = start a check automatically in the first cycle after reset deasserts.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse requesting a (re)check. Honoured only in IDLE or DONE.
- avm_address  out  1  word select: 0 = ID, 1 = timestamp.
- avm_read  out  1  Avalon read strobe.
- avm_waitrequest  in  1  slave stall. Tie 0 for the zero-wait sysid slave.
- avm_readdata  in  32  slave read data.
- busy  out  1  high from read issue until the verdict is posted.
- done  out  1  sticky; verdict valid.
- pass  out  1  sticky; meaningful only while done=1.
- error_code  out  2  0 none, 1 ID mismatch, 2 timestamp mismatch, 3 timeout.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). Sampled on the clock edge only.
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, pass=0, error_code=0, id_value=0, ts_value=0, state=IDLE, counters=0.
- Reset asserted mid-transaction: avm_read drops at that edge. No partial verdict is posted.

States: IDLE, REQ, LAT, CHECK, DONE.
- IDLE:
  - Enter REQ on start=1, or in the first cycle after reset deasserts when AUTO_START=1.
  - On entry to REQ: idx=0, done=0, pass=0, error_code=0, busy=1.
- REQ:
  - avm_read=1, avm_address=idx. Both held stable while avm_waitrequest=1.
  - Accept = avm_read & !avm_waitrequest.
  - On accept with READ_LATENCY=0: capture avm_readdata that same cycle (idx 0 -> id_value, idx 1 -> ts_value). If idx=0, set idx=1 and stay in REQ; the next read is issued the following cycle. If idx=1, go to CHECK.
  - On accept with READ_LATENCY>0: avm_read=0 next cycle, go to LAT.
  - Wait counter increments on each cycle with avm_waitrequest=1 and resets on accept.
  - When the counter reaches TIMEOUT: error_code=3, pass=0, done=1, busy=0, avm_read=0, go to DONE.
- LAT:
  - Counts cycles after accept.
  - Captures avm_readdata exactly READ_LATENCY cycles after the accept edge.
  - Then advances idx, or goes to CHECK, using the same rules as REQ.
- CHECK (exactly one cycle):
  - id_value != EXPECTED_ID -> error_code=1. Takes precedence if both words mismatch.
  - Else ts_value != EXPECTED_TS -> error_code=2.
  - Else error_code=0 and pass=1.
  - Set done=1, busy=0, go to DONE.
- DONE:
  - Outputs held.
  - start=1 behaves as from IDLE: done/pass/error_code clear at the next edge and a new sequence begins.
- start while busy: ignored; no queueing.
- Latency with zero-wait slave and READ_LATENCY=0: start at cycle T -> reads at T+1 and T+2, CHECK at T+3, done=1 visible at T+4. Auto-start: the first read occurs in the first cycle after reset deasserts.
- Never asserts avm_read during CHECK, DONE or IDLE.
- Never issues more than 2 reads per sequence.

Test Plan:
1. Auto-start, zero-wait slave returning 0 then 1683891951 -> avm_read high for 2 cycles with address 0 then 1. done=1, pass=1, error_code=0 four cycles after reset release.
2. Slave returns 32'h12345678 at address 0 -> id_value=32'h12345678, pass=0, error_code=1. ts_value still captured.
3. waitrequest held high for 3 cycles on each read, READ_LATENCY=2 -> address/read stable while stalled, data captured 2 cycles after each accept, pass=1, busy high for 13 cycles.
4. waitrequest stuck high, TIMEOUT=10 -> after 10 stall cycles: avm_read=0, done=1, pass=0, error_code=3, and no further reads.
5. start pulse in DONE with timestamp now 1683891950 -> done clears next cycle, new reads issued, final error_code=2, pass=0. Extra start pulses while busy change nothing.
6. reset asserted while avm_read=1 on the second read -> all outputs 0 at that edge. After release with AUTO_START=1, a full fresh sequence completes with pass=1.
